// File: rtl/tap_ctrl_param.sv
// tap_ctrl_param: parametrised 1149.1-style TAP controller.
// 16-state TAP FSM, IR_WIDTH-bit instruction register and four data
// registers (bypass, IDCODE, boundary scan, user) selected by the active
// instruction. Any cycle spent in Test-Logic-Reset holds the controller in
// its reset configuration, whether reached through TRST or through TMS.
module tap_ctrl_param #(
    parameter int unsigned IR_WIDTH   = 4,
    parameter int unsigned BSR_WIDTH  = 8,
    parameter int unsigned USER_WIDTH = 16,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5679
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic                  TMS,
    input  logic                  TDI,
    output logic                  TDO,
    output logic                  tdo_en,
    output logic [3:0]            state,
    output logic [IR_WIDTH-1:0]   ir_out,
    input  logic [BSR_WIDTH-1:0]  bsr_pins_in,
    output logic [BSR_WIDTH-1:0]  bsr_update_out,
    output logic [USER_WIDTH-1:0] user_out,
    output logic                  test_mode,
    output logic                  capture_dr,
    output logic                  shift_dr,
    output logic                  update_dr,
    output logic                  shift_ir,
    output logic                  update_ir
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,
        SEL_DR = 4'd2,  CAP_DR = 4'd3,  SH_DR  = 4'd4,  EX1_DR = 4'd5,
        PAU_DR = 4'd6,  EX2_DR = 4'd7,  UPD_DR = 4'd8,
        SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11, EX1_IR = 4'd12,
        PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_e;

    typedef enum logic [1:0] {DR_BSR, DR_IDCODE, DR_USER, DR_BYPASS} dr_sel_e;

    localparam logic [IR_WIDTH-1:0] OP_EXTEST  = IR_WIDTH'(0);
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_INTEST  = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(3);
    localparam logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(4);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    tap_state_e            state_q, state_d;
    dr_sel_e               dr_sel;
    logic                  clear;
    logic [IR_WIDTH-1:0]   ir_shift;
    logic [BSR_WIDTH-1:0]  bsr_shift;
    logic [31:0]           id_shift;
    logic [USER_WIDTH-1:0] user_shift;
    logic                  bypass_reg;

    // Registers are cleared on every edge that lands in (or stays in) TLR,
    // so they read as reset for the whole time the FSM sits there.
    assign clear = TRST || (state_d == TLR);

    // State register; TRST wins over TMS on the same edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge TCK) begin
        if (TRST) state_q <= TLR;
        else      state_q <= state_d;
    end

    // Next-state logic: standard 1149.1 TMS graph.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = TMS ? TLR    : RTI;
            RTI:    state_d = TMS ? SEL_DR : RTI;
            SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_d = TMS ? SEL_DR : RTI;
            SEL_IR: state_d = TMS ? TLR    : CAP_IR;
            CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_d = TMS ? SEL_DR : RTI;
        endcase
    end

    // Instruction decode to data-register select; unknown codes act as BYPASS.
    always_comb begin
        dr_sel = DR_BYPASS;
        case (ir_out)
            OP_EXTEST, OP_SAMPLE, OP_INTEST: dr_sel = DR_BSR;
            OP_IDCODE:                       dr_sel = DR_IDCODE;
            OP_USER:                         dr_sel = DR_USER;
            default:                         dr_sel = DR_BYPASS;
        endcase
    end

    // Instruction register: capture pattern, right shift, update to ir_out.
    always_ff @(posedge TCK) begin
        if (clear) begin
            ir_shift <= '0;
            ir_out   <= OP_IDCODE;
        end else begin
            case (state_q)
                CAP_IR:  ir_shift <= IR_CAPTURE;
                SH_IR:   ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
                UPD_IR:  ir_out   <= ir_shift;
                default: ;
            endcase
        end
    end

    // Data shift registers: only the selected one captures or shifts.
    always_ff @(posedge TCK) begin
        if (clear) begin
            bsr_shift  <= '0;
            id_shift   <= '0;
            user_shift <= '0;
            bypass_reg <= 1'b0;
        end else if (state_q == CAP_DR) begin
            case (dr_sel)
                DR_BSR:    bsr_shift  <= bsr_pins_in;
                DR_IDCODE: id_shift   <= IDCODE_VAL;
                DR_USER:   user_shift <= user_out;
                default:   bypass_reg <= 1'b0;
            endcase
        end else if (state_q == SH_DR) begin
            case (dr_sel)
                DR_BSR:    bsr_shift  <= {TDI, bsr_shift[BSR_WIDTH-1:1]};
                DR_IDCODE: id_shift   <= {TDI, id_shift[31:1]};
                DR_USER:   user_shift <= {TDI, user_shift[USER_WIDTH-1:1]};
                default:   bypass_reg <= TDI;
            endcase
        end
    end

    // Update latches, written only while leaving Update-DR.
    always_ff @(posedge TCK) begin
        if (clear) begin
            bsr_update_out <= '0;
            user_out       <= '0;
        end else if (state_q == UPD_DR) begin
            case (dr_sel)
                DR_BSR:  bsr_update_out <= bsr_shift;
                DR_USER: user_out       <= user_shift;
                default: ;
            endcase
        end
    end

    // Serial output: LSB of whichever register is shifting, else 0.
    always_comb begin
        TDO = 1'b0;
        if (state_q == SH_IR) begin
            TDO = ir_shift[0];
        end else if (state_q == SH_DR) begin
            case (dr_sel)
                DR_BSR:    TDO = bsr_shift[0];
                DR_IDCODE: TDO = id_shift[0];
                DR_USER:   TDO = user_shift[0];
                default:   TDO = bypass_reg;
            endcase
        end
    end

    assign state      = state_q;
    assign tdo_en     = (state_q == SH_IR) || (state_q == SH_DR);
    assign test_mode  = (ir_out == OP_EXTEST) || (ir_out == OP_INTEST);
    assign capture_dr = (state_q == CAP_DR);
    assign shift_dr   = (state_q == SH_DR);
    assign update_dr  = (state_q == UPD_DR);
    assign shift_ir   = (state_q == SH_IR);
    assign update_ir  = (state_q == UPD_IR);

endmodule

// File: tb/tb_tap_ctrl_param.sv
// tb_tap_ctrl_param: directed scenarios followed by random TMS/TDI/TRST
// traffic, with every output compared each cycle against a table-driven
// behavioural model of the TAP.
module tb_tap_ctrl_param;

    logic        TCK = 1'b0;
    logic        TRST, TMS, TDI;
    logic        TDO, tdo_en, test_mode;
    logic [3:0]  state, ir_out;
    logic [7:0]  bsr_pins_in, bsr_update_out;
    logic [15:0] user_out;
    logic        capture_dr, shift_dr, update_dr, shift_ir, update_ir;

    tap_ctrl_param #(
        .IR_WIDTH(4), .BSR_WIDTH(8), .USER_WIDTH(16), .IDCODE_VAL(32'h1234_5679)
    ) dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .tdo_en(tdo_en),
        .state(state), .ir_out(ir_out), .bsr_pins_in(bsr_pins_in),
        .bsr_update_out(bsr_update_out), .user_out(user_out), .test_mode(test_mode),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .shift_ir(shift_ir), .update_ir(update_ir)
    );

    always #5 TCK = ~TCK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // nxt_tbl[s] = '{next when TMS=0, next when TMS=1}
    int          nxt_tbl [16][2];
    int          m_state;
    logic [3:0]  m_irs, m_ir;
    logic        m_byp;
    logic [31:0] m_id;
    logic [7:0]  m_bsr, m_bsr_upd;
    logic [15:0] m_usr, m_user;
    logic        obs_tdo;

    // 0=BSR, 1=IDCODE, 2=USER, 3=bypass
    function automatic int m_sel(input logic [3:0] ir);
        if (ir <= 4'd2) return 0;
        if (ir == 4'd3) return 1;
        if (ir == 4'd4) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_state = 0; m_irs = 4'd0; m_ir = 4'd3; m_byp = 1'b0; m_id = 32'd0;
        m_bsr = 8'd0; m_bsr_upd = 8'd0; m_usr = 16'd0; m_user = 16'd0;
    endtask

    task automatic model_step(input logic tms, input logic tdi, input logic trst);
        int s;
        s = m_sel(m_ir);
        case (m_state)
            3: begin
                if (s == 0) m_bsr = bsr_pins_in;
                else if (s == 1) m_id = 32'h1234_5679;
                else if (s == 2) m_usr = m_user;
                else m_byp = 1'b0;
            end
            4: begin
                if (s == 0) m_bsr = (m_bsr >> 1) | (8'(tdi) << 7);
                else if (s == 1) m_id = (m_id >> 1) | (32'(tdi) << 31);
                else if (s == 2) m_usr = (m_usr >> 1) | (16'(tdi) << 15);
                else m_byp = tdi;
            end
            8: begin
                if (s == 0) m_bsr_upd = m_bsr;
                else if (s == 2) m_user = m_usr;
            end
            10: m_irs = 4'd1;
            11: m_irs = (m_irs >> 1) | (4'(tdi) << 3);
            15: m_ir = m_irs;
            default: ;
        endcase
        m_state = trst ? 0 : nxt_tbl[m_state][int'(tms)];
        if (m_state == 0) model_reset();
    endtask

    task automatic compare_outputs();
        logic e_tdo;
        int s;
        s = m_sel(m_ir);
        e_tdo = 1'b0;
        if (m_state == 11) e_tdo = m_irs[0];
        else if (m_state == 4)
            e_tdo = (s == 0) ? m_bsr[0] : (s == 1) ? m_id[0] : (s == 2) ? m_usr[0] : m_byp;
        check("state", 32'(state), 32'(m_state));
        check("tdo", 32'(TDO), 32'(e_tdo));
        check("tdo_en", 32'(tdo_en), 32'(m_state == 4 || m_state == 11));
        check("ir_out", 32'(ir_out), 32'(m_ir));
        check("test_mode", 32'(test_mode), 32'(m_ir == 4'd0 || m_ir == 4'd2));
        check("bsr_update_out", 32'(bsr_update_out), 32'(m_bsr_upd));
        check("user_out", 32'(user_out), 32'(m_user));
        check("strobes", {27'd0, capture_dr, shift_dr, update_dr, shift_ir, update_ir},
              {27'd0, m_state == 3, m_state == 4, m_state == 8, m_state == 11, m_state == 15});
    endtask

    // One TCK cycle: called at a falling edge, drives inputs, compares the
    // current outputs, lets the rising edge happen, advances the model.
    task automatic tick(input logic tms, input logic tdi = 1'b0, input logic trst = 1'b0);
        TMS = tms; TDI = tdi; TRST = trst;
        #1;
        compare_outputs();
        obs_tdo = TDO;
        @(posedge TCK);
        #1;
        model_step(tms, tdi, trst);
        @(negedge TCK);
    endtask

    // RTI -> IR scan of 4 bits -> RTI
    task automatic scan_ir(input logic [3:0] din, output logic [3:0] dout);
        tick(1); tick(1); tick(0); tick(0);
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, din[i]);
            dout[i] = obs_tdo;
        end
        tick(1); tick(0);
    endtask

    // RTI -> DR scan of n bits -> RTI
    task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        tick(1); tick(0); tick(0);
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, din[i]);
            dout[i] = obs_tdo;
        end
        tick(1); tick(0);
    endtask

    logic [31:0] dout;
    logic [3:0]  irout;
    int          exp_seq [5];

    initial begin
        nxt_tbl = '{'{1, 0}, '{1, 2}, '{3, 9}, '{4, 5}, '{4, 5}, '{6, 8}, '{6, 7}, '{4, 8},
                    '{1, 2}, '{10, 0}, '{11, 12}, '{11, 12}, '{13, 15}, '{13, 14}, '{11, 15}, '{1, 2}};
        exp_seq = '{5, 8, 2, 9, 0};
        TRST = 1'b1; TMS = 1'b0; TDI = 1'b0; bsr_pins_in = 8'h00;
        @(posedge TCK);
        #1;
        model_reset();
        @(negedge TCK);

        // Reset and IDCODE readout
        check("rst_state", 32'(state), 32'd0);
        check("rst_ir_out", 32'(ir_out), 32'd3);
        tick(0); tick(1); tick(0); tick(0);
        dout = '0;
        for (int i = 0; i < 32; i++) begin
            tick(i == 31);
            dout[i] = obs_tdo;
        end
        check("idcode_stream", dout, 32'h1234_5679);
        tick(1); tick(0);

        // IR capture and load
        scan_ir(4'b0010, irout);
        check("ir_capture", 32'(irout), 32'd1);
        check("ir_load", 32'(ir_out), 32'd2);
        check("ir_test_mode", 32'(test_mode), 32'd1);

        // Bypass: 1,0,1,1 in -> 0,1,0,1 out
        scan_ir(4'hF, irout);
        scan_dr(4, 32'hD, dout);
        check("bypass_stream", dout, 32'hA);

        // EXTEST update, held through Pause-DR
        bsr_pins_in = 8'h3C;
        scan_ir(4'h0, irout);
        scan_dr(8, 32'hA5, dout);
        check("extest_capture", dout, 32'h3C);
        check("extest_update", 32'(bsr_update_out), 32'hA5);
        check("extest_test_mode", 32'(test_mode), 32'd1);
        tick(1); tick(0); tick(1); tick(0); tick(0);
        check("pause_state", 32'(state), 32'd6);
        check("pause_hold", 32'(bsr_update_out), 32'hA5);
        tick(1); tick(1); tick(0);

        // TMS reset path from Shift-DR
        tick(1); tick(0); tick(0);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check($sformatf("tms_path_%0d", k), 32'(state), 32'(exp_seq[k]));
        end
        check("tms_path_ir", 32'(ir_out), 32'd3);
        check("tms_path_bsr", 32'(bsr_update_out), 32'd0);

        // Reset in the 3rd Shift-DR cycle of a USER scan
        tick(0);
        scan_ir(4'h4, irout);
        tick(1); tick(0); tick(0);
        tick(0, 1'b1); tick(0, 1'b0);
        tick(0, 1'b1, 1'b1);
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_user", 32'(user_out), 32'd0);
        check("midrst_upd", {30'd0, update_dr, update_ir}, 32'd0);

        // USER round trip: update, then read back through capture
        tick(0);
        scan_ir(4'h4, irout);
        scan_dr(16, 32'hBEEF, dout);
        check("user_first", dout, 32'h0);
        check("user_update", 32'(user_out), 32'hBEEF);
        scan_dr(16, 32'h1234, dout);
        check("user_readback", dout, 32'hBEEF);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            bsr_pins_in = 8'($urandom);
            tick($urandom_range(99) < 35, 1'($urandom), $urandom_range(299) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
